// File: rtl/sap1_pkg.sv
// SAP-1 controller shared definitions.
// Control-bit indices, opcodes and T-state encoding.
package sap1_pkg;

  localparam int NUM_T_DEF = 5;

  localparam int CO  = 0;
  localparam int J   = 1;
  localparam int CE  = 2;
  localparam int OI  = 3;
  localparam int BI  = 4;
  localparam int SU  = 5;
  localparam int EO  = 6;
  localparam int AO  = 7;
  localparam int AI  = 8;
  localparam int II  = 9;
  localparam int IO  = 10;
  localparam int RO  = 11;
  localparam int RI  = 12;
  localparam int MI  = 13;
  localparam int FI  = 14;
  localparam int HLT = 15;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  function automatic logic [15:0] cb(input int i);
    return 16'd1 << i;
  endfunction

endpackage

// File: rtl/sap1_microcode.sv
// SAP-1 microcode ROM.
// Maps opcode/T-state/flags to the control word.
module sap1_microcode
  import sap1_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  tstate,
  input  logic        carry_q,
  input  logic        zero_q,
  output logic [15:0] ctrl,
  output logic        last
);

  logic [2:0] len;

  // instruction length, control word and last-step flag
  always_comb begin
    len  = 3'd2;
    ctrl = '0;
    case (opcode)
      OP_LDA, OP_STA: len = 3'd4;
      OP_ADD, OP_SUB: len = 3'd5;
      OP_LDI, OP_JMP,
      OP_JC,  OP_JZ,
      OP_OUT, OP_HLT: len = 3'd3;
      default:        len = 3'd2;
    endcase
    case (tstate)
      3'd0: ctrl = cb(CO) | cb(MI);
      3'd1: ctrl = cb(RO) | cb(II) | cb(CE);
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD,
          OP_SUB, OP_STA:
            ctrl = cb(IO) | cb(MI);
          OP_LDI: ctrl = cb(IO) | cb(AI);
          OP_JMP: ctrl = cb(IO) | cb(J);
          OP_JC:
            ctrl = carry_q ? (cb(IO) | cb(J))
                           : 16'h0000;
          OP_JZ:
            ctrl = zero_q ? (cb(IO) | cb(J))
                          : 16'h0000;
          OP_OUT: ctrl = cb(AO) | cb(OI);
          OP_HLT: ctrl = cb(HLT);
          default: ctrl = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA: ctrl = cb(RO) | cb(AI);
          OP_ADD, OP_SUB:
            ctrl = cb(RO) | cb(BI);
          OP_STA: ctrl = cb(AO) | cb(RI);
          default: ctrl = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:
            ctrl = cb(EO) | cb(AI) | cb(FI);
          OP_SUB:
            ctrl = cb(EO) | cb(AI) | cb(FI)
                 | cb(SU);
          default: ctrl = '0;
        endcase
      end
      default: ctrl = '0;
    endcase
    last = (tstate == len - 3'd1);
  end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer.
// T-state counter, flags, halt latch around the ROM.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int NUM_T = NUM_T_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  opcode,
  input  logic        carry_in,
  input  logic        zero_in,
  output logic [15:0] ctrl,
  output logic [2:0]  tstate,
  output logic        halted
);

  localparam logic [2:0] T_MAX = 3'(NUM_T - 1);

  tstate_e     state_q, state_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        halted_q, halted_d;
  logic [15:0] rom_ctrl;
  logic        last;

  sap1_microcode u_rom (
    .opcode  (opcode),
    .tstate  (state_q),
    .carry_q (carry_q),
    .zero_q  (zero_q),
    .ctrl    (rom_ctrl),
    .last    (last)
  );

  // state, flag and halt registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= T0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      halted_q <= halted_d;
    end
  end

  // sequencing: halt, early termination, flag load
  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    halted_d = halted_q;
    if (en && !halted_q) begin
      if (rom_ctrl[HLT]) begin
        halted_d = 1'b1;
      end else if (last || state_q == T_MAX) begin
        state_d = T0;
      end else begin
        state_d = tstate_e'(state_q + 3'd1);
      end
      if (rom_ctrl[FI]) begin
        carry_d = carry_in;
        zero_d  = zero_in;
      end
    end
  end

  assign ctrl   = halted_q ? cb(HLT) : rom_ctrl;
  assign tstate = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Testbench for sap1_controller.
// Random stimulus against a microcode-table model.
module tb_sap1_controller;

  localparam logic [15:0] B_CO  = 16'h0001;
  localparam logic [15:0] B_J   = 16'h0002;
  localparam logic [15:0] B_CE  = 16'h0004;
  localparam logic [15:0] B_OI  = 16'h0008;
  localparam logic [15:0] B_BI  = 16'h0010;
  localparam logic [15:0] B_SU  = 16'h0020;
  localparam logic [15:0] B_EO  = 16'h0040;
  localparam logic [15:0] B_AO  = 16'h0080;
  localparam logic [15:0] B_AI  = 16'h0100;
  localparam logic [15:0] B_II  = 16'h0200;
  localparam logic [15:0] B_IO  = 16'h0400;
  localparam logic [15:0] B_RO  = 16'h0800;
  localparam logic [15:0] B_RI  = 16'h1000;
  localparam logic [15:0] B_MI  = 16'h2000;
  localparam logic [15:0] B_FI  = 16'h4000;
  localparam logic [15:0] B_HLT = 16'h8000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  opcode;
  logic        carry_in;
  logic        zero_in;
  logic [15:0] ctrl;
  logic [2:0]  tstate;
  logic        halted;

  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_t;
  logic m_c, m_z, m_h;

  sap1_controller dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .opcode   (opcode),
    .carry_in (carry_in),
    .zero_in  (zero_in),
    .ctrl     (ctrl),
    .tstate   (tstate),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  function automatic int op_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      4'h5, 4'h6, 4'h7, 4'h8,
      4'hE, 4'hF: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [15:0] exec_word(
    input logic [3:0] op, input int k,
    input logic c, input logic z);
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      4'h1: begin
        if (k == 0) w = B_IO | B_MI;
        if (k == 1) w = B_RO | B_AI;
      end
      4'h2, 4'h3: begin
        if (k == 0) w = B_IO | B_MI;
        if (k == 1) w = B_RO | B_BI;
        if (k == 2) begin
          w = B_EO | B_AI | B_FI;
          if (op == 4'h3) w = w | B_SU;
        end
      end
      4'h4: begin
        if (k == 0) w = B_IO | B_MI;
        if (k == 1) w = B_AO | B_RI;
      end
      4'h5: w = B_IO | B_AI;
      4'h6: w = B_IO | B_J;
      4'h7: w = c ? (B_IO | B_J) : 16'h0;
      4'h8: w = z ? (B_IO | B_J) : 16'h0;
      4'hE: w = B_AO | B_OI;
      4'hF: w = B_HLT;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] exp_ctrl();
    if (m_h) return B_HLT;
    if (m_t == 0) return B_CO | B_MI;
    if (m_t == 1) return B_RO | B_II | B_CE;
    return exec_word(opcode, m_t - 2, m_c, m_z);
  endfunction

  // one clock edge; advances the model with pre-edge inputs
  task automatic step(input logic e);
    logic [15:0] w;
    en = e;
    w  = exp_ctrl();
    if (!m_h && e) begin
      if (w[15]) begin
        m_h = 1'b1;
      end else begin
        if (w[14]) begin
          m_c = carry_in;
          m_z = zero_in;
        end
        if (m_t == op_len(opcode) - 1) m_t = 0;
        else m_t = m_t + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    m_t = 0; m_c = 1'b0; m_z = 1'b0; m_h = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; opcode = 4'h0;
    carry_in = 1'b0; zero_in = 1'b0;
    m_t = 0; m_c = 1'b0; m_z = 1'b0; m_h = 1'b0;
    #3;
    n_cmp++;
    if ({halted, tstate, ctrl} !== {1'b0, 3'd0, 16'h2001}) begin
      n_bad++;
      $display("FAIL reset: h=%0b t=%0d ctrl=%h want 0/0/2001",
               halted, tstate, ctrl);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] seq [5];
    seq = '{16'h2001, 16'h0A04, 16'h2400,
            16'h0810, 16'h4140};
    opcode = 4'h2; carry_in = 1'b1; zero_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ctrl !== seq[i] || tstate !== 3'(i)) begin
        n_bad++;
        $display("FAIL add_t%0d: ctrl=%h t=%0d want %h/%0d",
                 i, ctrl, tstate, seq[i], i);
      end
      step(1'b1);
    end
    carry_in = 1'b0; zero_in = 1'b0;
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_bad++;
      $display("FAIL add_wrap: t=%0d want 0", tstate);
    end
    opcode = 4'h8;
    step(1'b1); step(1'b1);
    n_cmp++;
    if (ctrl !== 16'h0402) begin
      n_bad++;
      $display("FAIL add_zflag: ctrl=%h want 0402", ctrl);
    end
    step(1'b1);
  endtask

  task automatic test_early_term();
    int exp_t [6];
    exp_t = '{0, 1, 2, 0, 1, 0};
    opcode = 4'h5;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) opcode = 4'h0;
      n_cmp++;
      if (tstate !== 3'(exp_t[i])) begin
        n_bad++;
        $display("FAIL early_term_%0d: t=%0d want %0d",
                 i, tstate, exp_t[i]);
      end
      if (i < 5) step(1'b1);
    end
  endtask

  task automatic test_jc();
    for (int pass = 0; pass < 2; pass++) begin
      opcode = 4'h2;
      carry_in = pass[0]; zero_in = 1'b0;
      repeat (5) step(1'b1);
      opcode = 4'h7;
      step(1'b1); step(1'b1);
      n_cmp++;
      if (ctrl !== (pass == 1 ? 16'h0402 : 16'h0000)) begin
        n_bad++;
        $display("FAIL jc_c%0d: ctrl=%h", pass, ctrl);
      end
      step(1'b1);
      n_cmp++;
      if (tstate !== 3'd0) begin
        n_bad++;
        $display("FAIL jc_len_c%0d: t=%0d want 0",
                 pass, tstate);
      end
    end
  endtask

  task automatic test_halt();
    opcode = 4'hF;
    step(1'b1); step(1'b1);
    step(1'b1);
    for (int i = 0; i < 21; i++) begin
      n_cmp++;
      if ({halted, tstate, ctrl} !== {1'b1, 3'd2, 16'h8000}) begin
        n_bad++;
        $display("FAIL halt_%0d: h=%0b t=%0d ctrl=%h",
                 i, halted, tstate, ctrl);
      end
      opcode = 4'($urandom);
      if (i < 20) step(1'b1);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({halted, tstate, ctrl} !== {1'b0, 3'd0, 16'h2001}) begin
      n_bad++;
      $display("FAIL halt_reset: h=%0b t=%0d ctrl=%h",
               halted, tstate, ctrl);
    end
    m_t = 0; m_c = 1'b0; m_z = 1'b0; m_h = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_en_random();
    logic [15:0] seq [5];
    logic [15:0] got [$];
    seq = '{16'h2001, 16'h0A04, 16'h2400,
            16'h0810, 16'h4160};
    opcode = 4'h3;
    for (int i = 0; i < 80 && got.size() < 5; i++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      carry_in = 1'($urandom);
      zero_in  = 1'($urandom);
      if (e) got.push_back(ctrl);
      step(e);
      n_cmp++;
      if ({halted, tstate, ctrl} !==
          {m_h, 3'(m_t), exp_ctrl()}) begin
        n_bad++;
        $display("FAIL sub_en_%0d: t=%0d ctrl=%h want %0d/%h",
                 i, tstate, ctrl, m_t, exp_ctrl());
      end
    end
    n_cmp++;
    if (got.size() != 5) begin
      n_bad++;
      $display("FAIL sub_en_timeout: %0d of 5 edges",
               got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== seq[i]) begin
        n_bad++;
        $display("FAIL sub_seq_%0d: ctrl=%h want %h",
                 i, got[i], seq[i]);
      end
    end
    for (int j = 0; j < 2; j++) begin
      opcode = (j == 0) ? 4'h7 : 4'h8;
      for (int i = 0; i < 3; i++) begin
        carry_in = 1'($urandom);
        zero_in  = 1'($urandom);
        step(1'b1);
        n_cmp++;
        if ({tstate, ctrl} !== {3'(m_t), exp_ctrl()}) begin
          n_bad++;
          $display("FAIL sub_flag_%0d_%0d: t=%0d ctrl=%h want %0d/%h",
                   j, i, tstate, ctrl, m_t, exp_ctrl());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    opcode = 4'h2; carry_in = 1'b1; zero_in = 1'b1;
    repeat (5) step(1'b1);
    opcode = 4'h1;
    repeat (3) step(1'b1);
    n_cmp++;
    if (tstate !== 3'd3) begin
      n_bad++;
      $display("FAIL lda_t3: t=%0d want 3", tstate);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({halted, tstate, ctrl} !== {1'b0, 3'd0, 16'h2001}) begin
      n_bad++;
      $display("FAIL async_reset: h=%0b t=%0d ctrl=%h",
               halted, tstate, ctrl);
    end
    m_t = 0; m_c = 1'b0; m_z = 1'b0; m_h = 1'b0;
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      opcode = (j == 0) ? 4'h7 : 4'h8;
      step(1'b1); step(1'b1);
      n_cmp++;
      if (ctrl !== 16'h0000) begin
        n_bad++;
        $display("FAIL flags_cleared_%0d: ctrl=%h want 0000",
                 j, ctrl);
      end
      step(1'b1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_h && $urandom_range(0, 3) == 0) pulse_reset();
      if (m_t == 0 && !m_h) opcode = 4'($urandom);
      carry_in = 1'($urandom);
      zero_in  = 1'($urandom);
      step($urandom_range(0, 3) != 0);
      n_cmp++;
      if ({halted, tstate, ctrl} !==
          {m_h, 3'(m_t), exp_ctrl()}) begin
        n_bad++;
        $display("FAIL rand_%0d: op=%h h=%0b t=%0d ctrl=%h want %0b/%0d/%h",
                 i, opcode, halted, tstate, ctrl,
                 m_h, m_t, exp_ctrl());
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_early_term();
    test_jc();
    test_halt();
    test_en_random();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
